// File: rtl/gate_truth_table_checker.sv
// Self-test engine: sweeps all 2**N_IN input vectors through a combinational gate,
// samples its response after SETTLE cycles per vector and compares against EXPECT.
module gate_truth_table_checker #(
  parameter int                      N_IN   = 2,
  parameter int                      SETTLE = 1,
  parameter logic [(1<<N_IN)-1:0]    EXPECT = 4'b1110
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_err
);

  localparam int NV = 1 << N_IN;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] IDX_LAST = N_IN'(NV - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0] dut_in_q, dut_in_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_count_q, err_count_d;
  logic [N_IN-1:0] first_err_q, first_err_d;
  logic            mismatch;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    dut_in_d    = dut_in_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    first_err_d = first_err_q;
    // Case inequality so an X/Z response from the gate counts as a failure.
    mismatch    = (dut_out !== EXPECT[idx_q]);

    case (state_q)
      IDLE: begin
        busy_d   = 1'b0;
        dut_in_d = '0;
        if (start) begin
          state_d     = RUN;
          idx_d       = '0;
          cnt_d       = '0;
          busy_d      = 1'b1;
          err_count_d = '0;
          first_err_d = '0;
          pass_d      = 1'b0;
        end
      end
      RUN: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          if (mismatch) begin
            err_count_d = err_count_q + 1'b1;
            if (err_count_q == '0) first_err_d = idx_q;
          end
          cnt_d = '0;
          if (idx_q != IDX_LAST) begin
            idx_d    = idx_q + 1'b1;
            dut_in_d = idx_q + 1'b1;
          end else begin
            state_d  = IDLE;
            idx_d    = '0;
            dut_in_d = '0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            pass_d   = (err_count_d == '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from
  // the same pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      dut_in_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      dut_in_q    <= dut_in_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      first_err_q <= first_err_d;
    end
  end

  assign dut_in    = dut_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign first_err = first_err_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Bench for gate_truth_table_checker: a table-driven gate (default config) and a
// two-stage registered OR gate (SETTLE=3), checked against a truth-table model.
module tb_gate_truth_table_checker;

  localparam logic [3:0] EXP = 4'b1110;

  logic       clk, rst;
  logic       start, start3;
  logic [1:0] dut_in, dut_in3;
  logic       dut_out, dut_out3;
  logic       busy, done, pass, busy3, done3, pass3;
  logic [2:0] err_count, err_count3;
  logic [1:0] first_err, first_err3;

  logic [3:0] gate_tbl;
  logic       x_en;
  logic [1:0] x_vec;
  logic       p1, p2;

  int n_checks = 0;
  int n_errors = 0;

  gate_truth_table_checker u_dut (
    .clk(clk), .rst(rst), .start(start), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .first_err(first_err)
  );

  gate_truth_table_checker #(.N_IN(2), .SETTLE(3), .EXPECT(4'b1110)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .dut_in(dut_in3), .dut_out(dut_out3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err_count3), .first_err(first_err3)
  );

  // Gate under test for the default instance: any truth table, optional X on one vector.
  always_comb dut_out = (x_en && dut_in == x_vec) ? 1'bx : gate_tbl[dut_in];

  // a|b behind two register stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1 <= 1'b0;
      p2 <= 1'b0;
    end else begin
      p1 <= dut_in3[0] | dut_in3[1];
      p2 <= p1;
    end
  end
  assign dut_out3 = p2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: compare each truth-table entry as the gate presents it against EXP.
  task automatic model(input logic [3:0] tbl, input logic xe, input logic [1:0] xv,
                       output int errs, output int first);
    logic b;
    errs  = 0;
    first = 0;
    for (int i = 0; i < 4; i++) begin
      b = (xe && i == int'(xv)) ? 1'bx : tbl[i];
      if (b !== EXP[i]) begin
        if (errs == 0) first = i;
        errs++;
      end
    end
  endtask

  // Full sweep on the default instance; called at a negedge with the checker idle.
  task automatic sweep(input string tag, input logic [3:0] tbl, input logic xe,
                       input logic [1:0] xv);
    int errs, first;
    model(tbl, xe, xv, errs, first);
    gate_tbl = tbl;
    x_en     = xe;
    x_vec    = xv;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_dut_in"}, 32'(dut_in), 32'(i));
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_done_early"}, 32'(done), 32'd0);
      @(negedge clk);
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_dut_in_end"}, 32'(dut_in), 32'd0);
    check({tag, "_err_count"}, 32'(err_count), 32'(errs));
    check({tag, "_pass"}, 32'(pass), 32'(errs == 0));
    if (errs != 0) check({tag, "_first_err"}, 32'(first_err), 32'(first));
    @(negedge clk);
    check({tag, "_done_clear"}, 32'(done), 32'd0);
    check({tag, "_err_hold"}, 32'(err_count), 32'(errs));
    x_en = 1'b0;
  endtask

  initial begin
    logic [3:0] rtbl;
    rst      = 1'b1;
    start    = 1'b0;
    start3   = 1'b0;
    gate_tbl = 4'b1110;
    x_en     = 1'b0;
    x_vec    = 2'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_first", 32'(first_err), 32'd0);
    check("rst_dut_in", 32'(dut_in), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    sweep("or_gate", 4'b1110, 1'b0, 2'd0);
    sweep("and_gate", 4'b1000, 1'b0, 2'd0);
    sweep("x_vec3", 4'b1110, 1'b1, 2'd3);
    for (int t = 0; t < 8; t++) begin
      rtbl = 4'($urandom_range(0, 15));
      sweep("rand_tbl", rtbl, 1'b0, 2'd0);
    end

    // Reset mid-sweep at idx 2 with an AND gate (one mismatch already counted).
    gate_tbl = 4'b1000;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_dut_in", 32'(dut_in), 32'd2);
    check("mid_err", 32'(err_count), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_dut_in", 32'(dut_in), 32'd0);
    check("mid_rst_err", 32'(err_count), 32'd0);
    check("mid_rst_first", 32'(first_err), 32'd0);
    check("mid_rst_pass", 32'(pass), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_no_done", 32'(done), 32'd0);
      check("mid_idle_busy", 32'(busy), 32'd0);
    end
    sweep("after_rst", 4'b1110, 1'b0, 2'd0);

    // start held high: ignored while busy, re-accepted in the done cycle.
    gate_tbl = 4'b1000;
    start    = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_busy", 32'(busy), 32'd1);
      check("hold_dut_in", 32'(dut_in), 32'(i));
    end
    @(negedge clk);
    check("hold_done1", 32'(done), 32'd1);
    check("hold_err1", 32'(err_count), 32'd2);
    check("hold_first1", 32'(first_err), 32'd1);
    check("hold_pass1", 32'(pass), 32'd0);
    gate_tbl = 4'b1110;
    @(negedge clk);
    check("hold_restart_busy", 32'(busy), 32'd1);
    check("hold_restart_err", 32'(err_count), 32'd0);
    check("hold_restart_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check("hold_done_early", 32'(done), 32'd0);
    @(negedge clk);
    check("hold_done2", 32'(done), 32'd1);
    check("hold_pass2", 32'(pass), 32'd1);
    check("hold_err2", 32'(err_count), 32'd0);
    start = 1'b0;
    @(negedge clk);

    // SETTLE=3 with a latency-2 OR gate.
    start3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start3 = 1'b0;
    for (int j = 0; j < 12; j++) begin
      check("s3_dut_in", 32'(dut_in3), 32'(j / 3));
      check("s3_busy", 32'(busy3), 32'd1);
      check("s3_done_early", 32'(done3), 32'd0);
      @(negedge clk);
    end
    check("s3_done", 32'(done3), 32'd1);
    check("s3_pass", 32'(pass3), 32'd1);
    check("s3_err", 32'(err_count3), 32'd0);
    check("s3_busy_end", 32'(busy3), 32'd0);
    @(negedge clk);
    check("s3_done_clear", 32'(done3), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
